seq_det_event_logger: RTL and testbench

SEQ_DET_EVENT_LOGGER -- requirements
Module: seq_det_event_logger

---
 rtl/seq_det_event_logger.sv | 99 +++++++++
 tb/tb_seq_det_event_logger.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_det_event_logger.sv
// Rising-edge event logger: timestamps 0->1 transitions of an upstream detector
// output into a 4-entry first-word-fall-through FIFO, with a saturating event count and a sticky overflow flag.
module seq_det_event_logger #(
    parameter int TS_W  = 16,
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             det_in,
    input  logic             evt_ready,
    input  logic             clear_ovf,
    output logic             evt_valid,
    output logic [TS_W-1:0]  evt_data,
    output logic [CNT_W-1:0] evt_count,
    output logic             overflow,
    output logic [2:0]       fifo_level
);

    localparam logic [2:0] FULL_LVL = 3'(DEPTH);

    logic [TS_W-1:0]  ts_q, ts_d;
    logic             det_q;
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [2:0]       level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [TS_W-1:0]  mem_q [4];

    logic detect, pop, full, push, drop;

    assign detect = det_in & ~det_q & enable;
    assign pop    = (level_q != 3'd0) & evt_ready;
    assign full   = (level_q == FULL_LVL);
    // A full FIFO still accepts an event when the head leaves in the same cycle.
    assign push   = detect & (~full | pop);
    assign drop   = detect & full & ~pop;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latch).
        ts_d     = ts_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;

        if (enable) ts_d = ts_q + 1'b1;
        if (push)   wr_ptr_d = wr_ptr_q + 2'd1;
        if (pop)    rd_ptr_d = rd_ptr_q + 2'd1;

        case ({push, pop})
            2'b10:   level_d = level_q + 3'd1;
            2'b01:   level_d = level_q - 3'd1;
            default: level_d = level_q;
        endcase

        // Dropped events still count; the counter sticks at all-ones.
        if (detect && cnt_q != '1) cnt_d = cnt_q + 1'b1;

        if (drop)           ovf_d = 1'b1;
        else if (clear_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            ts_q     <= '0;
            det_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ts_q     <= ts_d;
            det_q    <= det_in;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: the storage array is not reset; level gates evt_valid, so stale contents are never observed.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= ts_q;
    end

    assign evt_valid  = (level_q != 3'd0);
    assign evt_data   = mem_q[rd_ptr_q];
    assign evt_count  = cnt_q;
    assign overflow   = ovf_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_seq_det_event_logger.sv
// Directed bench for seq_det_event_logger: edge capture, FIFO fill/drain,
// overflow set/clear priority, timestamp wrap, count saturation and async reset.
module tb_seq_det_event_logger;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        det_in;
    logic        evt_ready;
    logic        clear_ovf;
    logic        evt_valid;
    logic [15:0] evt_data;
    logic [7:0]  evt_count;
    logic        overflow;
    logic [2:0]  fifo_level;

    int checks   = 0;
    int failures = 0;

    seq_det_event_logger dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .det_in     (det_in),
        .evt_ready  (evt_ready),
        .clear_ovf  (clear_ovf),
        .evt_valid  (evt_valid),
        .evt_data   (evt_data),
        .evt_count  (evt_count),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        det_in    = 1'b0;
        evt_ready = 1'b0;
        clear_ovf = 1'b0;
        tick(2);
        reset  = 1'b0;
        enable = 1'b1;
    endtask

    task automatic pulse();
        det_in = 1'b1;
        tick(1);
        det_in = 1'b0;
        tick(1);
    endtask

    initial begin
        // Reset state, then a level held high for 10 cycles starting at ts=5.
        do_reset();
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_count", 32'(evt_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        tick(5);
        det_in = 1'b1;
        check("no_bypass_valid", 32'(evt_valid), 32'd0);
        tick(1);
        check("lvl_valid", 32'(evt_valid), 32'd1);
        check("lvl_data", 32'(evt_data), 32'h5);
        check("lvl_count", 32'(evt_count), 32'd1);
        tick(9);
        check("lvl_single_entry", 32'(fifo_level), 32'd1);
        check("lvl_single_count", 32'(evt_count), 32'd1);
        det_in    = 1'b0;
        evt_ready = 1'b1;
        tick(1);
        check("lvl_drained", 32'(evt_valid), 32'd0);

        // Five pulses with no consumer: captures ts 0,2,4,6; the fifth drops.
        do_reset();
        for (int i = 0; i < 4; i++) pulse();
        check("fill_level4", 32'(fifo_level), 32'd4);
        check("fill_no_ovf", 32'(overflow), 32'd0);
        pulse();
        check("drop_level", 32'(fifo_level), 32'd4);
        check("drop_ovf", 32'(overflow), 32'd1);
        check("drop_count", 32'(evt_count), 32'd5);
        enable    = 1'b0;
        evt_ready = 1'b1;
        check("drain_0", 32'(evt_data), 32'h0);
        tick(1);
        check("drain_1", 32'(evt_data), 32'h2);
        tick(1);
        check("drain_2", 32'(evt_data), 32'h4);
        tick(1);
        check("drain_3", 32'(evt_data), 32'h6);
        tick(1);
        check("drain_empty", 32'(evt_valid), 32'd0);
        evt_ready = 1'b0;
        det_in    = 1'b1;
        tick(1);
        check("dis_no_event_lvl", 32'(fifo_level), 32'd0);
        check("dis_no_event_cnt", 32'(evt_count), 32'd5);
        det_in = 1'b0;

        // Full FIFO, new edge coincides with a pop: accepted, no overflow.
        do_reset();
        for (int i = 0; i < 4; i++) pulse();
        det_in    = 1'b1;
        evt_ready = 1'b1;
        tick(1);
        check("pp_level", 32'(fifo_level), 32'd4);
        check("pp_ovf", 32'(overflow), 32'd0);
        check("pp_count", 32'(evt_count), 32'd5);
        check("pp_head", 32'(evt_data), 32'h2);
        det_in    = 1'b0;
        evt_ready = 1'b0;
        tick(1);
        evt_ready = 1'b1;
        tick(3);
        check("pp_tail", 32'(evt_data), 32'h8);
        tick(1);
        check("pp_empty", 32'(evt_valid), 32'd0);
        evt_ready = 1'b0;

        // Drop and clear_ovf in the same cycle: set wins; clear alone then clears.
        for (int i = 0; i < 4; i++) pulse();
        check("sc_pre_ovf", 32'(overflow), 32'd0);
        det_in    = 1'b1;
        clear_ovf = 1'b1;
        tick(1);
        check("sc_set_wins", 32'(overflow), 32'd1);
        check("sc_count", 32'(evt_count), 32'd10);
        det_in = 1'b0;
        tick(1);
        check("sc_cleared", 32'(overflow), 32'd0);
        clear_ovf = 1'b0;

        // Timestamp wrap: edges at ts=0xFFFF and ts=0x0001.
        do_reset();
        tick(65535);
        det_in = 1'b1;
        tick(1);
        check("wrap_first_valid", 32'(evt_valid), 32'd1);
        check("wrap_first_data", 32'(evt_data), 32'hFFFF);
        det_in = 1'b0;
        tick(1);
        det_in = 1'b1;
        tick(1);
        det_in = 1'b0;
        check("wrap_level", 32'(fifo_level), 32'd2);
        evt_ready = 1'b1;
        tick(1);
        check("wrap_second_data", 32'(evt_data), 32'h0001);
        tick(1);
        check("wrap_empty", 32'(evt_valid), 32'd0);

        // Count saturation with a live consumer, then async reset with entries queued.
        do_reset();
        evt_ready = 1'b1;
        for (int i = 0; i < 254; i++) pulse();
        check("sat_254", 32'(evt_count), 32'd254);
        pulse();
        check("sat_255", 32'(evt_count), 32'd255);
        for (int i = 0; i < 45; i++) pulse();
        check("sat_hold", 32'(evt_count), 32'd255);
        check("sat_no_ovf", 32'(overflow), 32'd0);
        evt_ready = 1'b0;
        pulse();
        pulse();
        check("pre_rst_level", 32'(fifo_level), 32'd2);
        reset = 1'b1;
        #1;
        check("async_valid", 32'(evt_valid), 32'd0);
        check("async_count", 32'(evt_count), 32'd0);
        check("async_level", 32'(fifo_level), 32'd0);
        tick(1);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
